sevenseg_scan: RTL and testbench

SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

---
 rtl/sevenseg_pkg.sv | 16 +
 rtl/hex_to_7seg.sv | 11 +
 rtl/sevenseg_scan.sv | 116 +++++++++++
 tb/tb_sevenseg_scan.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types, blanking constants and hex-to-segment table for the 8-digit scanner.
package sevenseg_pkg;

  typedef logic [3:0] hex_t;
  typedef logic [6:0] seg_t;

  localparam seg_t       SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} patterns, indexed by hex value.
  localparam seg_t SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_7seg
  import sevenseg_pkg::*;
(
  input  hex_t hex,
  output seg_t seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed 8-digit seven-segment scanner with per-frame input snapshot.
// Optional decimal points (dp input, dot output) are enabled by defining SEVENSEG_DP_EN.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int FRAME_HZ  = 1000,
  parameter int BLANK_CYC = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  hex_t [7:0] digits,
  input  logic [7:0] enable,
`ifdef SEVENSEG_DP_EN
  input  logic [7:0] dp,
`endif
  output logic [7:0] an,
  output seg_t       digit,
  output logic       frame_sync
`ifdef SEVENSEG_DP_EN
  ,
  output logic       dot
`endif
);

  localparam int SLOT = CLK_HZ / (FRAME_HZ * 8);
  localparam int PW   = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam logic [PW-1:0] LAST  = PW'(SLOT - 1);
  localparam logic [PW-1:0] BLANK = PW'(BLANK_CYC);

  generate
    if (SLOT <= BLANK_CYC) begin : g_bad_slot
      $error("sevenseg_scan: slot length must exceed BLANK_CYC");
    end
  endgenerate

  logic [PW-1:0] presc, presc_nxt;
  logic [2:0]    idx, idx_nxt;
  logic          primed;
  logic          snap_take;
  logic          show;
  hex_t [7:0]    snap_digits, dig_src;
  logic [7:0]    snap_enable, en_src;
  seg_t          seg_dec;

  // The first edge after reset acts like a 7->0 wrap so slot 0 starts at once.
  always_comb begin
    presc_nxt = presc;
    idx_nxt   = idx;
    snap_take = 1'b0;
    if (!primed) begin
      presc_nxt = '0;
      idx_nxt   = '0;
      snap_take = 1'b1;
    end else if (presc == LAST) begin
      presc_nxt = '0;
      idx_nxt   = idx + 3'd1;
      snap_take = (idx == 3'd7);
    end else begin
      presc_nxt = presc + PW'(1);
    end
  end

  // Outputs are registered from next-state values so they align with the counters.
  assign dig_src = snap_take ? digits : snap_digits;
  assign en_src  = snap_take ? enable : snap_enable;
  assign show    = (presc_nxt >= BLANK);

  hex_to_7seg u_dec (
    .hex (dig_src[idx_nxt]),
    .seg (seg_dec)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      primed      <= 1'b0;
      presc       <= '0;
      idx         <= '0;
      snap_digits <= '0;
      snap_enable <= '0;
      frame_sync  <= 1'b0;
      an          <= AN_OFF;
      digit       <= SEG_BLANK;
    end else begin
      primed     <= 1'b1;
      presc      <= presc_nxt;
      idx        <= idx_nxt;
      frame_sync <= snap_take;
      if (snap_take) begin
        snap_digits <= digits;
        snap_enable <= enable;
      end
      an    <= (show && en_src[idx_nxt]) ? ~(8'h01 << idx_nxt) : AN_OFF;
      digit <= show ? seg_dec : SEG_BLANK;
    end
  end

`ifdef SEVENSEG_DP_EN
  logic [7:0] snap_dp, dp_src;

  assign dp_src = snap_take ? dp : snap_dp;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snap_dp <= '0;
      dot     <= 1'b1;
    end else begin
      if (snap_take) begin
        snap_dp <= dp;
      end
      dot <= ~(show && en_src[idx_nxt] && dp_src[idx_nxt]);
    end
  end
`endif

endmodule

// File: tb/tb_sevenseg_scan.sv
// Randomized self-checking bench for sevenseg_scan (SLOT=10, BLANK_CYC=2, 80-cycle frames).
module tb_sevenseg_scan;

  localparam logic [6:0] REF_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic            clock = 1'b0;
  logic            reset;
  logic [7:0][3:0] digits;
  logic [7:0]      enable;
  logic [7:0]      an;
  logic [6:0]      digit;
  logic            frame_sync;
`ifdef SEVENSEG_DP_EN
  logic [7:0]      dp;
  logic            dot;
`endif

  int checks = 0;
  int passes = 0;
  int k = 0;
  logic [3:0]  snap_d [8];
  logic [7:0]  snap_e;
  logic [7:0]  exp_an;
  logic [6:0]  exp_digit;
  logic        exp_sync;
  logic [15:0] got, want;

  sevenseg_scan #(
    .CLK_HZ    (8000),
    .FRAME_HZ  (100),
    .BLANK_CYC (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .digits     (digits),
    .enable     (enable),
`ifdef SEVENSEG_DP_EN
    .dp         (dp),
    .dot        (dot),
`endif
    .an         (an),
    .digit      (digit),
    .frame_sync (frame_sync)
  );

  always #5 clock = ~clock;

  // Reference: k counts cycles since reset release; frame = 80 cycles, slot = 10, first 2 blank.
  task automatic tick();
    int pos, slot;
    @(posedge clock);
    if (!reset) begin
      k = 0;
    end else begin
      k++;
      if ((k - 1) % 80 == 0) begin
        for (int i = 0; i < 8; i++) snap_d[i] = digits[i];
        snap_e = enable;
      end
    end
    if (k == 0) begin
      exp_an = 8'hFF; exp_digit = 7'h7F; exp_sync = 1'b0;
    end else begin
      pos  = (k - 1) % 10;
      slot = ((k - 1) / 10) % 8;
      exp_sync = ((k - 1) % 80 == 0);
      if (pos < 2) begin
        exp_an = 8'hFF; exp_digit = 7'h7F;
      end else begin
        exp_an    = snap_e[slot] ? ~(8'h01 << slot) : 8'hFF;
        exp_digit = REF_SEG[snap_d[slot]];
      end
    end
    got  = {an, digit, frame_sync};
    want = {exp_an, exp_digit, exp_sync};
    @(negedge clock);
    got = {an, digit, frame_sync};
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 8; i++) digits[i] = 4'($urandom_range(0, 15));
    enable = 8'($urandom);
`ifdef SEVENSEG_DP_EN
    dp = 8'($urandom);
`endif
  endtask

  task automatic test_reset();
    randomize_inputs();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (got !== {8'hFF, 7'h7F, 1'b0})
        $display("[TB] FAIL reset_hold c=%0d got %h want %h", c, got, {8'hFF, 7'h7F, 1'b0});
      else passes++;
    end
    reset = 1'b1;
    tick();
    checks++;
    if (frame_sync !== 1'b1 || an !== 8'hFF)
      $display("[TB] FAIL reset_first_sync got sync=%b an=%h want sync=1 an=ff", frame_sync, an);
    else passes++;
    for (int c = 0; c < 79; c++) begin
      tick();
      checks++;
      if (got !== want) $display("[TB] FAIL reset_frame k=%0d got %h want %h", k, got, want);
      else passes++;
    end
  endtask

  task automatic test_scan_order();
    for (int i = 0; i < 8; i++) digits[i] = 4'(i);
    enable = 8'hFF;
    for (int c = 0; c < 240; c++) begin
      tick();
      checks++;
      if (got !== want) $display("[TB] FAIL scan_order k=%0d got %h want %h", k, got, want);
      else passes++;
    end
  endtask

  task automatic test_enable_mask();
    randomize_inputs();
    enable = 8'b1010_1010;
    for (int c = 0; c < 200; c++) begin
      tick();
      checks++;
      if (got !== want) $display("[TB] FAIL enable_mask k=%0d got %h want %h", k, got, want);
      else passes++;
      if (k % 80 > 40 && k % 80 <= 50) begin
        checks++;
        if (an !== 8'hFF) $display("[TB] FAIL enable_mask_slot4 k=%0d got %h want ff", k, an);
        else passes++;
      end
    end
  endtask

  task automatic test_tearing();
    randomize_inputs();
    enable = 8'hFF;
    digits[3] = 4'h1;
    while (k % 80 != 0) begin
      tick();
      checks++;
      if (got !== want) $display("[TB] FAIL tear_align k=%0d got %h want %h", k, got, want);
      else passes++;
    end
    for (int c = 1; c <= 160; c++) begin
      tick();
      checks++;
      if (got !== want) $display("[TB] FAIL tearing k=%0d got %h want %h", k, got, want);
      else passes++;
      if (c == 36) begin
        checks++;
        if (digit !== 7'h79) $display("[TB] FAIL tear_old got %h want 79", digit);
        else passes++;
      end
      if (c == 116) begin
        checks++;
        if (digit !== 7'h00) $display("[TB] FAIL tear_new got %h want 00", digit);
        else passes++;
      end
      if (c == 55) digits[3] = 4'h8;
    end
  endtask

  task automatic test_decode();
    randomize_inputs();
    while (k % 80 != 0) begin
      tick();
      checks++;
      if (got !== want) $display("[TB] FAIL dec_align k=%0d got %h want %h", k, got, want);
      else passes++;
    end
    for (int v = 0; v < 16; v++) begin
      digits[0] = 4'(v);
      for (int c = 1; c <= 80; c++) begin
        tick();
        checks++;
        if (got !== want) $display("[TB] FAIL decode k=%0d got %h want %h", k, got, want);
        else passes++;
        if (c == 6) begin
          checks++;
          if (digit !== REF_SEG[v]) $display("[TB] FAIL decode_val v=%0d got %h want %h", v, digit, REF_SEG[v]);
          else passes++;
        end
      end
    end
  endtask

  task automatic test_midslot_reset();
    randomize_inputs();
    enable = 8'hFF;
    while (k % 80 != 0) begin
      tick();
      checks++;
      if (got !== want) $display("[TB] FAIL rst_align k=%0d got %h want %h", k, got, want);
      else passes++;
    end
    for (int c = 0; c < 47; c++) begin
      tick();
      checks++;
      if (got !== want) $display("[TB] FAIL pre_reset k=%0d got %h want %h", k, got, want);
      else passes++;
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({an, digit, frame_sync} !== {8'hFF, 7'h7F, 1'b0})
      $display("[TB] FAIL async_blank got %h want %h", {an, digit, frame_sync}, {8'hFF, 7'h7F, 1'b0});
    else passes++;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (got !== want) $display("[TB] FAIL in_reset got %h want %h", got, want);
      else passes++;
    end
    reset = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      checks++;
      if (got !== want) $display("[TB] FAIL post_reset k=%0d got %h want %h", k, got, want);
      else passes++;
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      randomize_inputs();
      for (int c = $urandom_range(20, 120); c > 0; c--) begin
        tick();
        checks++;
        if (got !== want) $display("[TB] FAIL random k=%0d got %h want %h", k, got, want);
        else passes++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    randomize_inputs();
    #1 reset = 1'b0;
    test_reset();
    test_scan_order();
    test_enable_mask();
    test_tearing();
    test_decode();
    test_midslot_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
